// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port.
// master: the arbiter's view; slave: the requesters and memory around it.
interface mem_port_arbiter_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] mem_rdata_q;

  modport master (
    input  i_valid, i_addr,
    output i_ready, i_rdata, i_err,
    input  d_valid, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rdata, d_err,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output mem_rdata_q
  );

  modport slave (
    output i_valid, i_addr,
    input  i_ready, i_rdata, i_err,
    output d_valid, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rdata, d_err,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  mem_rdata_q
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Grant watchdog: counts grant cycles without mem_ready; expire flags the
// edge on which the count would reach TIMEOUT.
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port with registered
// outputs, round-robin or data-priority tie break, and a grant timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transfer; requests sampled, winner captured on exit
// ST_GRANT_I | fetch request on the memory port, waiting for mem_ready
// ST_GRANT_D | data request on the memory port, waiting for mem_ready
// ST_RESP    | one-cycle ready pulse to the granted requester
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b0,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input logic                clk,
  input logic                resetn,
  mem_port_arbiter_if.master bus
);

  state_e      state_q, state_d;
  port_e       last_grant_q, last_grant_d, pick;
  logic        in_grant, expire, tmr_clear, tmr_en;
  logic        mem_valid_q, mem_valid_d, mem_instr_q, mem_instr_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        i_ready_q, i_ready_d, i_err_q, i_err_d;
  logic        d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0] rdata_last_q, rdata_last_d;

  assign in_grant  = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
  assign tmr_clear = (state_q == ST_IDLE);
  assign tmr_en    = in_grant && !bus.mem_ready;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk    (clk),
    .resetn (resetn),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (expire)
  );

  // winner among current requests; a tie goes to D under priority,
  // otherwise to the port that was not granted last
  always_comb begin
    pick = PORT_I;
    if (bus.d_valid && (!bus.i_valid || DATA_PRIO || (last_grant_q == PORT_I))) begin
      pick = PORT_D;
    end
  end

  // state and grant-history register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // next state; mem_ready beats an expiry on the same edge
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid || bus.d_valid) begin
          state_d      = (pick == PORT_D) ? ST_GRANT_D : ST_GRANT_I;
          last_grant_d = pick;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (bus.mem_ready || expire) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // next values of all registered outputs
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_instr_d  = mem_instr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    i_ready_d    = 1'b0;
    i_err_d      = 1'b0;
    d_ready_d    = 1'b0;
    d_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    rdata_last_d = rdata_last_q;
    if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
      mem_valid_d = 1'b1;
      mem_instr_d = (state_d == ST_GRANT_I);
      if (state_d == ST_GRANT_I) begin
        mem_addr_d  = bus.i_addr;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
      end else begin
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        mem_wstrb_d = bus.d_wstrb;
      end
    end
    if (in_grant && (state_d == ST_RESP)) begin
      mem_valid_d = 1'b0;
      mem_instr_d = 1'b0;
      if (state_q == ST_GRANT_I) begin
        i_ready_d = 1'b1;
        i_err_d   = !bus.mem_ready;
        if (bus.mem_ready) begin
          i_rdata_d    = bus.mem_rdata;
          rdata_last_d = bus.mem_rdata;
        end
      end else begin
        d_ready_d = 1'b1;
        d_err_d   = !bus.mem_ready;
        if (bus.mem_ready && (mem_wstrb_q == 4'b0000)) begin
          d_rdata_d    = bus.mem_rdata;
          rdata_last_d = bus.mem_rdata;
        end
      end
    end
  end

  // output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      mem_instr_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      i_ready_q    <= 1'b0;
      i_err_q      <= 1'b0;
      d_ready_q    <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      rdata_last_q <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_instr_q  <= mem_instr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      i_ready_q    <= i_ready_d;
      i_err_q      <= i_err_d;
      d_ready_q    <= d_ready_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      rdata_last_q <= rdata_last_d;
    end
  end

  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_instr   = mem_instr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wstrb   = mem_wstrb_q;
  assign bus.i_ready     = i_ready_q;
  assign bus.i_err       = i_err_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.d_err       = d_err_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.mem_rdata_q = rdata_last_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut0 is round-robin, dut1 is data-priority,
// both with a 4-cycle timeout and fed the same requester inputs.
module tb_mem_port_arbiter;

  localparam int NEVER = 255;

  typedef struct {
    bit          iv;
    bit          dv;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstrb;
    int          lat;
    logic [31:0] rdata;
    bit          e_port_d;
    bit          e_err;
    int          e_cycles;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
  } vec_t;

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] last;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat;
  logic stray;
  logic [31:0] resp_data;
  int   cnt0 = 0;
  int   cnt1 = 0;
  bit   tie_phase;
  int   d1_grants = 0;
  int   i1_grants = 0;
  logic [31:0] m_i_rdata, m_d_rdata, m_last;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if bus0();
  mem_port_arbiter_if bus1();

  mem_port_arbiter #(.DATA_PRIO(1'b0), .TIMEOUT(4)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  mem_port_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT(4)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  assign bus1.i_valid = bus0.i_valid;
  assign bus1.i_addr  = bus0.i_addr;
  assign bus1.d_valid = bus0.d_valid;
  assign bus1.d_addr  = bus0.d_addr;
  assign bus1.d_wdata = bus0.d_wdata;
  assign bus1.d_wstrb = bus0.d_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_txn(bit pd, bit is_wr, bit err, logic [31:0] data);
    exp_t e;
    if (!err && !is_wr) begin
      if (pd) m_d_rdata = data;
      else    m_i_rdata = data;
      m_last = data;
    end
    e.port_d = pd;
    e.rdata  = pd ? m_d_rdata : m_i_rdata;
    e.err    = err;
    e.last   = m_last;
    sb.push_back(e);
  endfunction

  // memory models: ready after 'lat' grant cycles, plus optional stray ready
  always @(negedge clk) begin
    if (bus0.mem_valid) begin
      bus0.mem_ready = (cnt0 == lat) || stray;
      cnt0++;
    end else begin
      bus0.mem_ready = stray;
      cnt0 = 0;
    end
    bus0.mem_rdata = resp_data;
  end

  always @(negedge clk) begin
    if (bus1.mem_valid) begin
      bus1.mem_ready = (cnt1 == lat) || stray;
      cnt1++;
    end else begin
      bus1.mem_ready = stray;
      cnt1 = 0;
    end
    bus1.mem_rdata = resp_data;
  end

  // scoreboard on dut0 completions
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      chk("i_err_gated", 32'(bus0.i_err & ~bus0.i_ready), 32'd0);
      chk("d_err_gated", 32'(bus0.d_err & ~bus0.d_ready), 32'd0);
      if (bus0.i_ready || bus0.d_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ready_port", 32'(bus0.d_ready), 32'(e.port_d));
          chk("ready_single", 32'(bus0.i_ready & bus0.d_ready), 32'd0);
          chk("rdata", e.port_d ? bus0.d_rdata : bus0.i_rdata, e.rdata);
          chk("err", 32'(e.port_d ? bus0.d_err : bus0.i_err), 32'(e.err));
          chk("mem_rdata_q", bus0.mem_rdata_q, e.last);
        end
      end
    end
  end

  // data-priority dut grant tally during the tie sequence
  always @(negedge clk) begin
    if (tie_phase) begin
      if (bus1.d_ready) d1_grants++;
      if (bus1.i_ready) i1_grants++;
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_mem_valid"},   32'(bus0.mem_valid), 32'd0);
    chk({tag, "_mem_instr"},   32'(bus0.mem_instr), 32'd0);
    chk({tag, "_mem_addr"},    bus0.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"},   bus0.mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"},   32'(bus0.mem_wstrb), 32'd0);
    chk({tag, "_i_ready"},     32'(bus0.i_ready), 32'd0);
    chk({tag, "_d_ready"},     32'(bus0.d_ready), 32'd0);
    chk({tag, "_i_err"},       32'(bus0.i_err), 32'd0);
    chk({tag, "_d_err"},       32'(bus0.d_err), 32'd0);
    chk({tag, "_i_rdata"},     bus0.i_rdata, 32'd0);
    chk({tag, "_d_rdata"},     bus0.d_rdata, 32'd0);
    chk({tag, "_mem_rdata_q"}, bus0.mem_rdata_q, 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int cycles;
    bit done;
    @(negedge clk);
    lat          = v.lat;
    resp_data    = v.rdata;
    bus0.i_addr  = v.iaddr;
    bus0.d_addr  = v.daddr;
    bus0.d_wdata = v.dwdata;
    bus0.d_wstrb = v.dwstrb;
    bus0.i_valid = v.iv;
    bus0.d_valid = v.dv;
    expect_txn(v.e_port_d, v.e_port_d && (v.dwstrb != 4'd0), v.e_err, v.rdata);
    cycles = 0;
    done   = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (bus0.mem_valid) begin
        cycles++;
        chk("mem_addr", bus0.mem_addr, v.e_addr);
        chk("mem_instr", 32'(bus0.mem_instr), 32'(!v.e_port_d));
        chk("mem_wstrb", 32'(bus0.mem_wstrb), 32'(v.e_wstrb));
        if (v.e_port_d) chk("mem_wdata", bus0.mem_wdata, v.dwdata);
        bus0.i_addr  = ~v.iaddr;
        bus0.d_addr  = ~v.daddr;
        bus0.d_wdata = ~v.dwdata;
        bus0.d_wstrb = ~v.dwstrb;
      end
      if (bus0.i_ready || bus0.d_ready) begin
        done = 1'b1;
        chk("grant_cycles", 32'(cycles), 32'(v.e_cycles));
        bus0.i_valid = 1'b0;
        bus0.d_valid = 1'b0;
      end
    end
    chk("ready_seen", 32'(done), 32'd1);
    bus0.i_valid = 1'b0;
    bus0.d_valid = 1'b0;
    @(negedge clk);
    chk("ready_pulse_width", 32'({bus0.i_ready, bus0.d_ready}), 32'd0);
    chk("mem_valid_after", 32'(bus0.mem_valid), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t post;
    int   pulses;
    bit   seen;
    //            iv    dv    iaddr         daddr         dwdata        strb  lat    rdata         pd    err   cyc addr          strb
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        4'h0, 1,     32'h00C0_006F, 1'b0, 1'b0, 2, 32'h0000_0100, 4'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h0,        32'h0000_2000, 32'h0,        4'h0, 0,     32'h1122_3344, 1'b1, 1'b0, 1, 32'h0000_2000, 4'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h0,        32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 2,     32'hBAD0_BAD0, 1'b1, 1'b0, 3, 32'h0000_2000, 4'h3};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        32'h0,        4'h0, NEVER, 32'h0BAD_F00D, 1'b0, 1'b1, 4, 32'h0000_0200, 4'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        32'h0,        4'h0, 3,     32'hCAFE_F00D, 1'b0, 1'b0, 4, 32'h0000_0300, 4'h0};
    tbl[5] = '{1'b0, 1'b1, 32'h0,        32'h0000_4000, 32'h0,        4'h0, NEVER, 32'h5555_5555, 1'b1, 1'b1, 4, 32'h0000_4000, 4'h0};
    tbl[6] = '{1'b0, 1'b1, 32'h0,        32'h0000_4004, 32'h1234_5678, 4'hF, 0,     32'h9999_9999, 1'b1, 1'b0, 1, 32'h0000_4004, 4'hF};
    tbl[7] = '{1'b0, 1'b1, 32'h0,        32'h0000_4008, 32'h0,        4'h0, 2,     32'hA5A5_A5A5, 1'b1, 1'b0, 3, 32'h0000_4008, 4'h0};
    post   = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        4'h0, 1,     32'h00C0_006F, 1'b0, 1'b0, 2, 32'h0000_0100, 4'h0};

    resetn       = 1'b0;
    stray        = 1'b0;
    lat          = NEVER;
    resp_data    = 32'h0;
    tie_phase    = 1'b0;
    bus0.i_valid = 1'b0;
    bus0.i_addr  = 32'h0;
    bus0.d_valid = 1'b0;
    bus0.d_addr  = 32'h0;
    bus0.d_wdata = 32'h0;
    bus0.d_wstrb = 4'h0;
    m_i_rdata    = 32'h0;
    m_d_rdata    = 32'h0;
    m_last       = 32'h0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    resetn = 1'b1;

    // both ports held: round-robin D,I,D,I; priority dut D every time
    @(negedge clk);
    lat          = 1;
    resp_data    = 32'h0000_0077;
    bus0.i_addr  = 32'h0000_0500;
    bus0.d_addr  = 32'h0000_0600;
    bus0.d_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) expect_txn((k % 2) == 0, 1'b0, 1'b0, 32'h0000_0077);
    tie_phase    = 1'b1;
    bus0.i_valid = 1'b1;
    bus0.d_valid = 1'b1;
    pulses = 0;
    for (int t = 0; t < 60 && pulses < 4; t++) begin
      @(negedge clk);
      if (bus0.i_ready || bus0.d_ready) pulses++;
    end
    bus0.i_valid = 1'b0;
    bus0.d_valid = 1'b0;
    @(negedge clk);
    tie_phase = 1'b0;
    chk("tie_pulses", 32'(pulses), 32'd4);
    chk("prio_d_grants", 32'(d1_grants), 32'd4);
    chk("prio_i_grants", 32'(i1_grants), 32'd0);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) run_txn(tbl[k]);

    // stray mem_ready while idle must not produce a completion
    stray = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_ready", 32'({bus0.i_ready, bus0.d_ready}), 32'd0);
      chk("stray_mem_valid", 32'(bus0.mem_valid), 32'd0);
    end
    stray = 1'b0;
    @(negedge clk);

    // reset during a data grant
    lat          = NEVER;
    bus0.d_addr  = 32'h0000_8000;
    bus0.d_wstrb = 4'h0;
    bus0.d_valid = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus0.mem_valid) seen = 1'b1;
    end
    chk("grant_before_reset", 32'(seen), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    bus0.d_valid = 1'b0;
    m_i_rdata    = 32'h0;
    m_d_rdata    = 32'h0;
    m_last       = 32'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_ready_after_reset", 32'({bus0.i_ready, bus0.d_ready}), 32'd0);
    end
    run_txn(post);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
